// File: rtl/video_in_pkg.sv
// -----------------------------------------------------------------------------
// video_in_pkg
// Shared definitions for the video input path: nominal frame geometry and the
// FIFO entry layout used between the pixel packer and its word buffer.
// -----------------------------------------------------------------------------
package video_in_pkg;

   localparam int p_WIDTH           = 640;
   localparam int p_HEIGHT          = 480;
   localparam int p_PIX_PER_WORD    = 4;
   localparam int p_WORDS_PER_FRAME = p_WIDTH * p_HEIGHT / p_PIX_PER_WORD;

   // One buffered word plus its frame-start tag; sof is the MSB of the entry.
   typedef struct packed {
      logic        sof;
      logic [31:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/video_in_fifo_mem.sv
// -----------------------------------------------------------------------------
// video_in_fifo_mem
// p_DEPTH x 33-bit storage array for the packed-pixel FIFO: one synchronous
// write port and one asynchronous (combinational) read port, so the head entry
// is visible without a read cycle.
//
// Ports:
//   clk     - write clock
//   w_en    - write enable
//   w_addr  - write address (FIFO tail)
//   w_data  - entry to store
//   r_addr  - read address (FIFO head)
//   r_data  - entry at r_addr, combinational
// -----------------------------------------------------------------------------
module video_in_fifo_mem
   import video_in_pkg::*;
#(
   parameter int p_DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       w_en,
   input  logic [$clog2(p_DEPTH)-1:0] w_addr,
   input  fifo_entry_t                w_data,
   input  logic [$clog2(p_DEPTH)-1:0] r_addr,
   output fifo_entry_t                r_data
);

   fifo_entry_t mem [p_DEPTH];

   // NOTE: the array is deliberately not reset; entry validity is tracked by
   // the pointers and level in the parent, and a reset would prevent RAM mapping.
   always_ff @(posedge clk) begin
      if (w_en) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/video_in_pack_fifo.sv
// -----------------------------------------------------------------------------
// video_in_pack_fifo
// Packs four consecutive 8-bit pixels (first pixel in the LSB byte) into a
// 32-bit word and buffers words in a first-word-fall-through FIFO drained by
// the frame-writing bus master. Words carry a start-of-frame tag; sticky flags
// record dropped words (overflow) and partial words discarded at a frame
// start (misalign).
//
// Ports:
//   clk, nRST    - clock, asynchronous active-low reset
//   w_e          - pixel write strobe, one pixel per asserted cycle
//   pixel_in     - pixel value
//   frame_start  - marks the current w_e pixel as first pixel of a frame
//   r_e          - pop request; ignored while empty
//   data_out     - head word (zero while empty)
//   sof_out      - head word holds the first pixel of a frame
//   empty, full  - FIFO occupancy status
//   level        - stored word count, 0..p_DEPTH
//   overflow     - sticky: completed word dropped because FIFO was full
//   misalign     - sticky: partial word discarded at frame_start
//   clr_err      - synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module video_in_pack_fifo
   import video_in_pkg::*;
#(
   parameter int p_DEPTH = 64,
   parameter int p_PIX_W = 8
) (
   input  logic                     clk,
   input  logic                     nRST,
   input  logic                     w_e,
   input  logic [p_PIX_W-1:0]       pixel_in,
   input  logic                     frame_start,
   input  logic                     r_e,
   output logic [31:0]              data_out,
   output logic                     sof_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(p_DEPTH):0] level,
   output logic                     overflow,
   output logic                     misalign,
   input  logic                     clr_err
);

   localparam int AW = $clog2(p_DEPTH);
   localparam int LW = AW + 1;

   // Packer state: bytes 0..2 of the word under construction; byte 3 comes
   // straight from pixel_in on the completing cycle.
   logic [1:0]             lane;
   logic [3*p_PIX_W-1:0]   part;
   logic                   part_sof;

   // FIFO control state.
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [LW-1:0]          level_q;
   logic                   empty_q;
   logic                   full_q;
   logic                   overflow_q;
   logic                   misalign_q;

   // Combinational decisions.
   logic [1:0]             eff_lane;
   logic                   fs_pix;
   logic                   word_sof;
   logic                   push;
   logic                   do_pop;
   logic                   do_write;
   logic                   ovf_evt;
   logic                   mis_evt;
   logic [LW-1:0]          level_nxt;
   fifo_entry_t            push_entry;
   fifo_entry_t            head;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      fs_pix     = w_e && frame_start;
      eff_lane   = fs_pix ? 2'd0 : lane;
      word_sof   = fs_pix ? 1'b1 : part_sof;
      push       = w_e && (eff_lane == 2'd3);
      mis_evt    = fs_pix && (lane != 2'd0);
      do_pop     = r_e && !empty_q;
      // A full FIFO still accepts a push when the same cycle frees the head.
      do_write   = push && (!full_q || do_pop);
      ovf_evt    = push && full_q && !do_pop;
      push_entry = '{sof: part_sof, data: {pixel_in, part}};
      level_nxt  = level_q;
      case ({do_write, do_pop})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

   // Packer: lane counter, partial word and its sof tag.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         lane     <= 2'd0;
         part     <= '0;
         part_sof <= 1'b0;
      end else if (w_e) begin
         if (push) begin
            lane     <= 2'd0;
            part_sof <= 1'b0;
         end else begin
            lane     <= eff_lane + 2'd1;
            part_sof <= word_sof;
            case (eff_lane)
               2'd0:    part[0*p_PIX_W +: p_PIX_W] <= pixel_in;
               2'd1:    part[1*p_PIX_W +: p_PIX_W] <= pixel_in;
               2'd2:    part[2*p_PIX_W +: p_PIX_W] <= pixel_in;
               default: ;
            endcase
         end
      end
   end

   // Pointers, occupancy and registered status.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
         level_q <= level_nxt;
         empty_q <= (level_nxt == '0);
         full_q  <= (level_nxt == LW'(p_DEPTH));
      end
   end

   // Sticky flags: an event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         overflow_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         overflow_q <= (overflow_q && !clr_err) || ovf_evt;
         misalign_q <= (misalign_q && !clr_err) || mis_evt;
      end
   end

   video_in_fifo_mem #(
      .p_DEPTH (p_DEPTH)
   ) u_mem (
      .clk    (clk),
      .w_en   (do_write),
      .w_addr (wr_ptr),
      .w_data (push_entry),
      .r_addr (rd_ptr),
      .r_data (head)
   );

   // Head is forced to zero while empty so reset and drained states read as 0
   // regardless of stale array contents.
   assign data_out = empty_q ? 32'd0 : head.data;
   assign sof_out  = empty_q ? 1'b0  : head.sof;
   assign empty    = empty_q;
   assign full     = full_q;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_video_in_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_video_in_pack_fifo
// Directed self-checking bench for video_in_pack_fifo (p_DEPTH=64).
// -----------------------------------------------------------------------------
module tb_video_in_pack_fifo;
   import video_in_pkg::*;

   localparam int DEPTH       = 64;
   localparam int FRAME_LINES = 40;
   localparam int FRAME_PIX   = p_WIDTH * FRAME_LINES;

   logic        clk;
   logic        nRST;
   logic        w_e;
   logic [7:0]  pixel_in;
   logic        frame_start;
   logic        r_e;
   logic [31:0] data_out;
   logic        sof_out;
   logic        empty;
   logic        full;
   logic [6:0]  level;
   logic        overflow;
   logic        misalign;
   logic        clr_err;

   int checks   = 0;
   int failures = 0;

   video_in_pack_fifo #(
      .p_DEPTH (DEPTH),
      .p_PIX_W (8)
   ) dut (
      .clk         (clk),
      .nRST        (nRST),
      .w_e         (w_e),
      .pixel_in    (pixel_in),
      .frame_start (frame_start),
      .r_e         (r_e),
      .data_out    (data_out),
      .sof_out     (sof_out),
      .empty       (empty),
      .full        (full),
      .level       (level),
      .overflow    (overflow),
      .misalign    (misalign),
      .clr_err     (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [7:0] v, input logic fs, input logic pop);
      w_e         = 1'b1;
      pixel_in    = v;
      frame_start = fs;
      r_e         = pop;
      step();
      w_e         = 1'b0;
      frame_start = 1'b0;
      r_e         = 1'b0;
   endtask

   task automatic pop_one();
      r_e = 1'b1;
      step();
      r_e = 1'b0;
   endtask

   // Word built from the pixel sequence 4j, 4j+1, 4j+2, 4j+3 (mod 256).
   function automatic logic [31:0] word_of(input int j);
      return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
   endfunction

   initial begin
      nRST = 1'b0; w_e = 1'b0; pixel_in = 8'h00; frame_start = 1'b0;
      r_e = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      check("rst_data",     data_out, 32'h0);
      check("rst_sof",      sof_out,  1'b0);
      check("rst_empty",    empty,    1'b1);
      check("rst_full",     full,     1'b0);
      check("rst_level",    level,    7'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_misalign", misalign, 1'b0);
      nRST = 1'b1;
      step();

      // First word with frame start.
      pix(8'h11, 1'b1, 1'b0);
      pix(8'h22, 1'b0, 1'b0);
      pix(8'h33, 1'b0, 1'b0);
      check("w0_not_yet", empty, 1'b1);
      pix(8'h44, 1'b0, 1'b0);
      check("w0_data",     data_out, 32'h44332211);
      check("w0_sof",      sof_out,  1'b1);
      check("w0_empty",    empty,    1'b0);
      check("w0_level",    level,    7'd1);
      check("w0_misalign", misalign, 1'b0);

      // Two more words, then drain in order.
      for (int k = 0; k < 8; k++) pix(8'(8'h55 + 8'(k) * 8'h11), 1'b0, 1'b0);
      check("w3_level", level, 7'd3);
      pop_one();
      check("pop1_data", data_out, 32'h88776655);
      check("pop1_sof",  sof_out,  1'b0);
      pop_one();
      check("pop2_data", data_out, 32'hCCBBAA99);
      check("pop2_sof",  sof_out,  1'b0);
      pop_one();
      check("pop3_empty", empty, 1'b1);
      check("pop3_level", level, 7'd0);
      check("pop3_data",  data_out, 32'h0);

      // Frame start in the middle of a word.
      pix(8'h01, 1'b0, 1'b0);
      pix(8'h02, 1'b0, 1'b0);
      check("mis_before", misalign, 1'b0);
      pix(8'hAA, 1'b1, 1'b0);
      check("mis_set",   misalign, 1'b1);
      check("mis_level0", level, 7'd0);
      pix(8'h03, 1'b0, 1'b0);
      pix(8'h04, 1'b0, 1'b0);
      pix(8'h05, 1'b0, 1'b0);
      check("mis_level1", level, 7'd1);
      check("mis_data",   data_out, 32'h050403AA);
      check("mis_sof",    sof_out,  1'b1);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      check("mis_clr", misalign, 1'b0);
      pop_one();
      check("mis_drained", empty, 1'b1);

      // Push and pop together while empty: only the push lands.
      pix(8'hE0, 1'b0, 1'b0);
      pix(8'hE1, 1'b0, 1'b0);
      pix(8'hE2, 1'b0, 1'b0);
      pix(8'hE3, 1'b0, 1'b1);
      check("epp_level", level, 7'd1);
      check("epp_data",  data_out, 32'hE3E2E1E0);
      pop_one();
      check("epp_empty", empty, 1'b1);

      // Fill to full.
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < 4; k++) pix(8'(4*i+k), 1'b0, 1'b0);
         if (i == DEPTH-2) begin
            check("fill63_full",  full,  1'b0);
            check("fill63_level", level, 7'd63);
         end
      end
      check("fill_full",  full,     1'b1);
      check("fill_level", level,    7'd64);
      check("fill_head",  data_out, word_of(0));

      // Overflow: completed word dropped.
      pix(8'hDE, 1'b0, 1'b0);
      pix(8'hAD, 1'b0, 1'b0);
      pix(8'hBE, 1'b0, 1'b0);
      check("ovf_before", overflow, 1'b0);
      pix(8'hEF, 1'b0, 1'b0);
      check("ovf_set",   overflow, 1'b1);
      check("ovf_level", level,    7'd64);
      check("ovf_head",  data_out, word_of(0));

      // Push and pop together while full.
      pix(8'hA0, 1'b0, 1'b0);
      pix(8'hA1, 1'b0, 1'b0);
      pix(8'hA2, 1'b0, 1'b0);
      pix(8'hA3, 1'b0, 1'b1);
      check("fpp_level", level,    7'd64);
      check("fpp_full",  full,     1'b1);
      check("fpp_head",  data_out, word_of(1));

      // Overflow event coincident with clr_err keeps the flag set.
      pix(8'hB0, 1'b0, 1'b0);
      pix(8'hB1, 1'b0, 1'b0);
      pix(8'hB2, 1'b0, 1'b0);
      clr_err = 1'b1;
      pix(8'hB3, 1'b0, 1'b0);
      clr_err = 1'b0;
      check("ovf_clr_race", overflow, 1'b1);
      check("ovf_clr_lvl",  level,    7'd64);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      check("ovf_clr", overflow, 1'b0);

      // Drain everything; last entry is the word pushed during the full pop.
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("drain_%0d", i), data_out,
               (i < DEPTH-1) ? word_of(i+1) : 32'hA3A2A1A0);
         pop_one();
      end
      check("drain_empty", empty, 1'b1);
      check("drain_full",  full,  1'b0);

      // Pops on an empty FIFO do nothing.
      repeat (3) pop_one();
      check("epop_level", level, 7'd0);
      check("epop_empty", empty, 1'b1);

      // Asynchronous reset mid-word with 5 words stored.
      for (int k = 0; k < 22; k++) pix(8'(8'h40 + k), 1'b0, 1'b0);
      check("pre_rst_level", level, 7'd5);
      #1 nRST = 1'b0;
      #2;
      check("arst_data",     data_out, 32'h0);
      check("arst_sof",      sof_out,  1'b0);
      check("arst_empty",    empty,    1'b1);
      check("arst_full",     full,     1'b0);
      check("arst_level",    level,    7'd0);
      check("arst_overflow", overflow, 1'b0);
      check("arst_misalign", misalign, 1'b0);
      @(posedge clk);
      #1 nRST = 1'b1;
      pix(8'h10, 1'b0, 1'b0);
      pix(8'h11, 1'b0, 1'b0);
      pix(8'h12, 1'b0, 1'b0);
      pix(8'h13, 1'b0, 1'b0);
      check("post_rst_data",  data_out, 32'h13121110);
      check("post_rst_sof",   sof_out,  1'b0);
      check("post_rst_level", level,    7'd1);
      pop_one();

      // Streaming frame: one pixel per clock, drain pops every 4th clock.
      begin
         int sent = 0;
         int rcvd = 0;
         int sofs = 0;
         int cyc  = 0;
         while ((sent < FRAME_PIX || rcvd < FRAME_PIX/4) && cyc < FRAME_PIX + 200) begin
            w_e         = (sent < FRAME_PIX);
            pixel_in    = 8'(sent);
            frame_start = (sent == 0);
            r_e         = (cyc % 4 == 3) && !empty;
            if (r_e) begin
               if (rcvd == 0) check("frame_sof0", sof_out, 1'b1);
               check($sformatf("frame_word_%0d", rcvd), data_out, word_of(rcvd));
               if (sof_out) sofs++;
               rcvd++;
            end
            step();
            if (sent < FRAME_PIX) sent++;
            cyc++;
         end
         w_e = 1'b0; frame_start = 1'b0; r_e = 1'b0;
         check("frame_words",    rcvd,     FRAME_PIX/4);
         check("frame_sofs",     sofs,     1);
         check("frame_overflow", overflow, 1'b0);
         check("frame_misalign", misalign, 1'b0);
         check("frame_empty",    empty,    1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
